regfile_sb: RTL

Parametrised register file with an integrated scoreboard, intended for the pipelined MIPS core.
- Provides NUM_RD combinational read ports and one synchronous write-back port.
- Optional write-to-read bypass.
- Per-register busy bits set at issue and cleared at write-back, so the decode stage detects RAW/WAW hazards without a separate scoreboard.
- Register 0 reads as zero and is never busy.

---
 rtl/regfile_sb.sv | 114 +++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Register file with a built-in busy-bit scoreboard: NUM_RD combinational read ports,
// one write-back port, issue-time busy marking and WAW stall detection.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_num,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_num,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_num,
    output logic                       iss_stall,
    output logic [ADDR_W:0]            busy_cnt,
    output logic                       err_wb_idle
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] data_q [1:DEPTH-1];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [DEPTH-1:0]  wr_mask_s;
    logic [DEPTH-1:0]  iss_mask_s;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;
    logic              err_q;
    logic              err_d;
    logic              wr_hit_s;
    logic              iss_nz_s;
    logic              iss_acc_s;
    logic              cnt_inc_s;
    logic              cnt_dec_s;
    logic [ADDR_W-1:0] rnum_s [NUM_RD];

    assign wr_hit_s   = wr_en && (wr_num != '0);
    assign iss_nz_s   = iss_en && (iss_num != '0);
    // A write-back landing on the same register in the same cycle frees it for reuse.
    assign iss_stall  = iss_nz_s && busy_q[iss_num] && !(wr_hit_s && (wr_num == iss_num));
    assign iss_acc_s  = iss_nz_s && !iss_stall;
    assign wr_mask_s  = wr_hit_s  ? ({{(DEPTH-1){1'b0}}, 1'b1} << wr_num)  : '0;
    assign iss_mask_s = iss_acc_s ? ({{(DEPTH-1){1'b0}}, 1'b1} << iss_num) : '0;
    assign busy_d     = (busy_q & ~wr_mask_s) | iss_mask_s;
    assign cnt_inc_s  = iss_acc_s && !busy_q[iss_num];
    assign cnt_dec_s  = wr_hit_s && busy_q[wr_num] && !(iss_acc_s && (iss_num == wr_num));
    assign err_d      = err_q | (wr_hit_s && !busy_q[wr_num]);

    assign busy_cnt    = busy_cnt_q;
    assign err_wb_idle = err_q;

    genvar g;
    for (g = 0; g < NUM_RD; g++) begin : g_rnum
        assign rnum_s[g] = rd_num[g*ADDR_W +: ADDR_W];
    end

    // Busy counter next state from the increment/decrement events of this edge.
    always_comb begin
        busy_cnt_d = busy_cnt_q;
        case ({cnt_inc_s, cnt_dec_s})
            2'b10:   busy_cnt_d = busy_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
            2'b01:   busy_cnt_d = busy_cnt_q - {{ADDR_W{1'b0}}, 1'b1};
            default: busy_cnt_d = busy_cnt_q;
        endcase
    end

    // Read ports: r0 is hard zero, optional same-cycle forwarding, else storage.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rnum_s[i] == '0) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
                rd_busy[i]                  = 1'b0;
            end else if ((BYPASS != 0) && wr_hit_s && (wr_num == rnum_s[i])) begin
                rd_data[i*DATA_W +: DATA_W] = wr_data;
                rd_busy[i]                  = 1'b0;
            end else begin
                rd_data[i*DATA_W +: DATA_W] = data_q[rnum_s[i]];
                rd_busy[i]                  = busy_q[rnum_s[i]];
            end
        end
    end

    // Data storage for r1..r(DEPTH-1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else if (wr_hit_s) begin
            data_q[wr_num] <= wr_data;
        end
    end

    // Scoreboard state: busy bits, their population count and the sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule
